// File: rtl/fetch_sequencer.sv
`timescale 1ns/1ps
// fetch_sequencer: program counter and run control for the core datapath.
// A level-sensitive req starts a run at address 0. Decode can then apply
// halt, absolute jumps, PC-relative branches and stalls. The run ends on
// halt, on an out-of-range control transfer, or on stepping past the last
// legal word. The last two cases also raise fault. cycle_cnt reports the
// number of RUN cycles in the run and saturates at its maximum value.
//
// Ports
//   clk, reset   : rising-edge clock; synchronous active-high reset
//   req          : start request (level)
//   halt         : halt opcode decoded at prog_ctr
//   stall        : hold prog_ctr this cycle
//   jump_en/tgt  : absolute redirect
//   branch_en/off: PC-relative redirect, signed two's-complement offset
//   prog_ctr     : instruction fetch address
//   fetch_valid  : prog_ctr is a live fetch
//   done         : run complete
//   fault        : run ended on an illegal transfer or fall-through
//   cycle_cnt    : RUN cycles in the current/last run (saturating)
module fetch_sequencer #(
    parameter int unsigned PC_W     = 10,
    parameter int unsigned PROG_LEN = 1024,
    parameter int unsigned OFF_W    = 8,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic             halt,
    input  logic             stall,
    input  logic             jump_en,
    input  logic [PC_W-1:0]  jump_tgt,
    input  logic             branch_en,
    input  logic [OFF_W-1:0] branch_off,
    output logic [PC_W-1:0]  prog_ctr,
    output logic             fetch_valid,
    output logic             done,
    output logic             fault,
    output logic [CNT_W-1:0] cycle_cnt
);

    // The branch arithmetic is wide enough that the sum can never wrap.
    // PROG_LEN may equal 2**PC_W, so it also fits.
    localparam int unsigned      EXT_W   = ((PC_W > OFF_W) ? PC_W : OFF_W) + 2;
    localparam logic [EXT_W-1:0] LEN_EXT = EXT_W'(PROG_LEN);
    localparam logic [PC_W-1:0]  LAST_PC = PC_W'(PROG_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;

    logic [EXT_W-1:0] pc_ext;
    logic [EXT_W-1:0] off_ext;
    logic [EXT_W-1:0] br_tgt;
    logic             br_ok;
    logic             jump_ok;

    logic [PC_W-1:0]  pc_next;
    logic             end_run;
    logic             end_fault;

    // Branch target: zero-extended PC plus sign-extended offset.
    // A set top bit means the target is negative.
    assign pc_ext  = {{(EXT_W-PC_W){1'b0}}, prog_ctr};
    assign off_ext = {{(EXT_W-OFF_W){branch_off[OFF_W-1]}}, branch_off};
    assign br_tgt  = pc_ext + off_ext;
    assign br_ok   = ~br_tgt[EXT_W-1] & (br_tgt < LEN_EXT);
    assign jump_ok = EXT_W'(jump_tgt) < LEN_EXT;

    // Next-PC selection while running, highest priority first.
    always_comb begin
        pc_next   = prog_ctr;
        end_run   = 1'b0;
        end_fault = 1'b0;
        if (halt) begin
            end_run = 1'b1;
        end else if (jump_en) begin
            if (jump_ok) begin
                pc_next = jump_tgt;
            end else begin
                end_run   = 1'b1;
                end_fault = 1'b1;
            end
        end else if (branch_en) begin
            if (br_ok) begin
                pc_next = br_tgt[PC_W-1:0];
            end else begin
                end_run   = 1'b1;
                end_fault = 1'b1;
            end
        end else if (!stall) begin
            // Running off the last word ends the run in place.
            // The PC does not wrap to 0.
            if (prog_ctr == LAST_PC) begin
                end_run   = 1'b1;
                end_fault = 1'b1;
            end else begin
                pc_next = prog_ctr + PC_W'(1);
            end
        end
    end

    // Run-control state machine with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            prog_ctr    <= '0;
            fetch_valid <= 1'b0;
            done        <= 1'b0;
            fault       <= 1'b0;
            cycle_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    fetch_valid <= 1'b0;
                    done        <= 1'b0;
                    if (req) begin
                        state       <= RUN;
                        prog_ctr    <= '0;
                        cycle_cnt   <= '0;
                        fault       <= 1'b0;
                        fetch_valid <= 1'b1;
                    end
                end
                RUN: begin
                    // The cycle that ends the run is still counted.
                    if (cycle_cnt != CNT_MAX) begin
                        cycle_cnt <= cycle_cnt + CNT_W'(1);
                    end
                    prog_ctr <= pc_next;
                    if (end_run) begin
                        state       <= DONE;
                        fetch_valid <= 1'b0;
                        done        <= 1'b1;
                        fault       <= end_fault;
                    end
                end
                DONE: begin
                    // fault and cycle_cnt are held here.
                    // The next start clears them.
                    if (!req) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    fetch_valid <= 1'b0;
                    done        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
`timescale 1ns/1ps
// Self-checking bench for fetch_sequencer.
// Small parameters (PROG_LEN=16, CNT_W=4) make the program-end and
// counter-saturation boundaries reachable in a few cycles.
module tb_fetch_sequencer;

    localparam int PC_W     = 7;
    localparam int PROG_LEN = 16;
    localparam int OFF_W    = 8;
    localparam int CNT_W    = 4;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic             clk;
    logic             reset;
    logic             req;
    logic             halt;
    logic             stall;
    logic             jump_en;
    logic [PC_W-1:0]  jump_tgt;
    logic             branch_en;
    logic [OFF_W-1:0] branch_off;
    logic [PC_W-1:0]  prog_ctr;
    logic             fetch_valid;
    logic             done;
    logic             fault;
    logic [CNT_W-1:0] cycle_cnt;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Reference model: the run as plain flags and integers.
    bit m_run;
    bit m_done;
    bit m_fault;
    int m_pc;
    int m_cnt;

    fetch_sequencer #(
        .PC_W    (PC_W),
        .PROG_LEN(PROG_LEN),
        .OFF_W   (OFF_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .halt       (halt),
        .stall      (stall),
        .jump_en    (jump_en),
        .jump_tgt   (jump_tgt),
        .branch_en  (branch_en),
        .branch_off (branch_off),
        .prog_ctr   (prog_ctr),
        .fetch_valid(fetch_valid),
        .done       (done),
        .fault      (fault),
        .cycle_cnt  (cycle_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic finish_model(input bit f);
        m_run   = 1'b0;
        m_done  = 1'b1;
        m_fault = f;
    endtask

    // One rising edge of the model, using the inputs as the DUT sampled them.
    task automatic model_step();
        int t;
        if (reset) begin
            m_run = 0; m_done = 0; m_fault = 0; m_pc = 0; m_cnt = 0;
        end else if (m_run) begin
            if (m_cnt < CNT_MAX) m_cnt++;
            if (halt) begin
                finish_model(1'b0);
            end else if (jump_en) begin
                if (int'(jump_tgt) < PROG_LEN) m_pc = int'(jump_tgt);
                else finish_model(1'b1);
            end else if (branch_en) begin
                t = m_pc + int'($signed(branch_off));
                if (t >= 0 && t < PROG_LEN) m_pc = t;
                else finish_model(1'b1);
            end else if (!stall) begin
                if (m_pc == PROG_LEN - 1) finish_model(1'b1);
                else m_pc++;
            end
        end else if (m_done) begin
            if (!req) m_done = 1'b0;
        end else if (req) begin
            m_run = 1; m_pc = 0; m_cnt = 0; m_fault = 0;
        end
    endtask

    // Advance one clock, then compare every output with the model at the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("prog_ctr",    32'(prog_ctr),    32'(m_pc));
        chk("fetch_valid", 32'(fetch_valid), 32'(m_run));
        chk("done",        32'(done),        32'(m_done));
        chk("fault",       32'(fault),       32'(m_fault));
        chk("cycle_cnt",   32'(cycle_cnt),   32'(m_cnt));
    endtask

    task automatic clear_ctl();
        halt = 0; stall = 0; jump_en = 0; branch_en = 0;
        jump_tgt = '0; branch_off = '0;
    endtask

    initial begin
        m_run = 0; m_done = 0; m_fault = 0; m_pc = 0; m_cnt = 0;
        reset = 1; req = 0;
        clear_ctl();

        // Reset state
        cycle();
        chk("rst_pc", 32'(prog_ctr), 0);
        chk("rst_fv", 32'(fetch_valid), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_cnt", 32'(cycle_cnt), 0);
        reset = 0;

        // Reset in the middle of a run, then no restart while req is low
        req = 1;
        cycle();
        chk("start_fv", 32'(fetch_valid), 1);
        chk("start_pc", 32'(prog_ctr), 0);
        repeat (4) cycle();
        chk("pre_rst_pc", 32'(prog_ctr), 4);
        reset = 1; req = 0;
        cycle();
        chk("midrst_pc", 32'(prog_ctr), 0);
        chk("midrst_fv", 32'(fetch_valid), 0);
        chk("midrst_cnt", 32'(cycle_cnt), 0);
        reset = 0;
        repeat (3) cycle();
        chk("norestart_fv", 32'(fetch_valid), 0);

        // Straight-line run, halt at address 6
        req = 1;
        cycle();
        repeat (6) cycle();
        chk("line_pc6", 32'(prog_ctr), 6);
        halt = 1;
        cycle();
        chk("halt_done", 32'(done), 1);
        chk("halt_cnt", 32'(cycle_cnt), 7);
        chk("halt_pc", 32'(prog_ctr), 6);
        chk("halt_fault", 32'(fault), 0);
        halt = 0;
        cycle();
        chk("done_hold", 32'(done), 1);
        req = 0;
        cycle();
        chk("idle_done", 32'(done), 0);
        chk("idle_cnt", 32'(cycle_cnt), 7);

        // Branch back, jump, stall, then halt together with a jump
        req = 1;
        cycle();
        repeat (4) cycle();
        branch_en = 1; branch_off = 8'hFD;
        cycle();
        chk("br_back_pc", 32'(prog_ctr), 1);
        clear_ctl();
        cycle();
        jump_en = 1; jump_tgt = 7'd10;
        cycle();
        chk("jump_pc", 32'(prog_ctr), 10);
        clear_ctl();
        stall = 1;
        repeat (3) cycle();
        chk("stall_pc", 32'(prog_ctr), 10);
        chk("stall_cnt", 32'(cycle_cnt), 10);
        stall = 0;
        cycle();
        chk("unstall_pc", 32'(prog_ctr), 11);
        chk("unstall_cnt", 32'(cycle_cnt), 11);
        halt = 1; jump_en = 1; jump_tgt = 7'd3;
        cycle();
        chk("halt_jump_pc", 32'(prog_ctr), 11);
        chk("halt_jump_done", 32'(done), 1);
        clear_ctl(); req = 0;
        cycle();

        // Branch to a negative address
        req = 1;
        cycle();
        repeat (2) cycle();
        branch_en = 1; branch_off = 8'hFB;
        cycle();
        chk("negbr_fault", 32'(fault), 1);
        chk("negbr_pc", 32'(prog_ctr), 2);
        clear_ctl(); req = 0;
        cycle();
        chk("negbr_fault_hold", 32'(fault), 1);

        // Jump to the last word, then fall through the end of the program
        req = 1;
        cycle();
        jump_en = 1; jump_tgt = 7'd15;
        cycle();
        chk("jump_last_pc", 32'(prog_ctr), 15);
        clear_ctl();
        cycle();
        chk("fall_fault", 32'(fault), 1);
        chk("fall_pc", 32'(prog_ctr), 15);
        req = 0;
        cycle();

        // Jumps to one past the end and beyond
        for (int k = 0; k < 2; k++) begin
            req = 1;
            cycle();
            jump_en = 1; jump_tgt = (k == 0) ? 7'd16 : 7'd20;
            cycle();
            chk("badjump_fault", 32'(fault), 1);
            chk("badjump_done", 32'(done), 1);
            clear_ctl(); req = 0;
            cycle();
        end

        // Forward branches that reach the last word and one past it
        req = 1;
        cycle();
        jump_en = 1; jump_tgt = 7'd9;
        cycle();
        clear_ctl(); branch_en = 1; branch_off = 8'd6;
        cycle();
        chk("fwdbr_pc", 32'(prog_ctr), 15);
        branch_off = 8'd1;
        cycle();
        chk("fwdbr_fault", 32'(fault), 1);
        clear_ctl(); req = 0;
        cycle();

        // Counter saturation, then a restart clears count and fault
        req = 1;
        cycle();
        stall = 1;
        repeat (20) cycle();
        chk("sat_cnt", 32'(cycle_cnt), CNT_MAX);
        clear_ctl(); jump_en = 1; jump_tgt = 7'd20;
        cycle();
        chk("sat_end_cnt", 32'(cycle_cnt), CNT_MAX);
        clear_ctl(); req = 0;
        cycle();
        req = 1;
        cycle();
        chk("restart_pc", 32'(prog_ctr), 0);
        chk("restart_cnt", 32'(cycle_cnt), 0);
        chk("restart_fault", 32'(fault), 0);

        // Randomised traffic against the model
        for (int i = 0; i < 500; i++) begin
            reset      = ($urandom_range(0, 49) == 0);
            req        = ($urandom_range(0, 9) != 0);
            halt       = ($urandom_range(0, 19) == 0);
            stall      = ($urandom_range(0, 4) == 0);
            jump_en    = ($urandom_range(0, 9) == 0);
            jump_tgt   = PC_W'($urandom_range(0, 20));
            branch_en  = ($urandom_range(0, 9) == 0);
            branch_off = OFF_W'(int'($urandom_range(0, 16)) - 8);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
